// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: clear request/ready, packed read ports and the write port.
// The master side (decode/writeback) drives addresses and write data; the slave is the register file.
interface reg_file_mp_if #(
  parameter int ADW = 5,
  parameter int DPW = 32,
  parameter int NRP = 2
);
  logic               clr_i;
  logic               ready_o;
  logic [NRP*ADW-1:0] addr_r;
  logic [NRP*DPW-1:0] rd;
  logic [ADW-1:0]     addr_w;
  logic               we;
  logic [DPW-1:0]     wd;

  modport master (
    output clr_i, addr_r, addr_w, we, wd,
    input  ready_o, rd
  );

  modport slave (
    input  clr_i, addr_r, addr_w, we, wd,
    output ready_o, rd
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with hardware clear sequencer and optional write bypass.
// Optional macro REG_FILE_ZERO_REG_EN hardwires entry 0 to zero (RISC-V x0).
module reg_file_mp #(
  parameter int ADW    = 5,
  parameter int DPW    = 32,
  parameter int NRP    = 2,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          arst_ni,
  reg_file_mp_if.slave  bus
);
  localparam int DEPTH = 2**ADW;

`ifdef REG_FILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [ADW-1:0] clr_ptr_q, clr_ptr_d;
  logic           ready_q, ready_d;
  logic [DPW-1:0] mem_q [DEPTH];
  logic           wr_en_s;
  logic [ADW-1:0] raddr_s;
  logic [NRP*DPW-1:0] rd_s;

  // Sequencer state, clear pointer and ready flag
  always_ff @(posedge clk or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic: sweep every entry once, then wait for a clear request
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + {{(ADW-1){1'b0}}, 1'b1};
        if (clr_ptr_q == ADW'(DEPTH-1)) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end
      IDLE: begin
        if (bus.clr_i) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_ptr_d = '0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // Writes are honoured only when the array is usable; entry 0 may be read-only
  always_comb begin
    if ((state_q == IDLE) && bus.we && !(ZERO_REG && (bus.addr_w == '0))) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Storage array, deliberately without reset; the sequencer defines its contents
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_en_s) begin
      mem_q[bus.addr_w] <= bus.wd;
    end
  end

  // Read ports: blanked during clear, x0 forced to zero, optional same-cycle forwarding
  always_comb begin
    rd_s    = '0;
    raddr_s = '0;
    for (int k = 0; k < NRP; k++) begin
      raddr_s = bus.addr_r[k*ADW +: ADW];
      if (!ready_q) begin
        rd_s[k*DPW +: DPW] = '0;
      end else if (ZERO_REG && (raddr_s == '0)) begin
        rd_s[k*DPW +: DPW] = '0;
      end else if ((BYPASS != 0) && bus.we && (bus.addr_w == raddr_s)) begin
        rd_s[k*DPW +: DPW] = bus.wd;
      end else begin
        rd_s[k*DPW +: DPW] = mem_q[raddr_s];
      end
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.rd      = rd_s;

endmodule
